// File: rtl/iic_eeprom_target_if.sv
// Open-drain I2C bus seen by the EEPROM target: SCL/SDA as sampled from the wire,
// plus the SDA pull-down enable driven back by the target.
interface iic_eeprom_target_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/iic_eeprom_target.sv
// I2C target modelling a 24C02-class EEPROM: byte/page writes, random/sequential/current reads.
// Optional write protect input wp_i is enabled by defining IIC_EEPROM_WP_EN.
module iic_eeprom_target #(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         ADDR_W    = 8,
  parameter int         PAGE_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef IIC_EEPROM_WP_EN
  input  logic              wp_i,
`endif
  iic_eeprom_target_if.slave bus,
  output logic              busy,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_WORD_ADDR, S_WORD_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
  } state_t;

  localparam logic [ADDR_W-1:0] PMASK = ADDR_W'(PAGE_SIZE - 1);

  // Array initialiser gives the erased-EEPROM image; reset never touches it.
  logic [7:0] r_mem [0:2**ADDR_W-1] = '{default: 8'hFF};

  logic [2:0]        r_scl, r_sda;
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [7:0]        r_sh, r_tx;
  logic [ADDR_W-1:0] r_ptr, r_waddr;
  logic [7:0]        r_wdata;
  logic              r_rw, r_nack, r_oe, r_busy, r_stb;
  logic              w_rise, w_fall, w_scl_hi, w_start, w_stop, w_sda, w_wp;

  // [1] is the synchronised level, [2] the history bit used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl <= 3'b111;
      r_sda <= 3'b111;
    end else begin
      r_scl <= {r_scl[1:0], bus.scl_i};
      r_sda <= {r_sda[1:0], bus.sda_i};
    end
  end

  assign w_rise   =  r_scl[1] & ~r_scl[2];
  assign w_fall   = ~r_scl[1] &  r_scl[2];
  assign w_scl_hi =  r_scl[1] &  r_scl[2];
  assign w_start  = w_scl_hi &  r_sda[2] & ~r_sda[1];
  assign w_stop   = w_scl_hi & ~r_sda[2] &  r_sda[1];
  assign w_sda    = r_sda[1];

`ifdef IIC_EEPROM_WP_EN
  logic [1:0] r_wp;
  always_ff @(posedge clk) begin
    if (rst) r_wp <= 2'b00;
    else     r_wp <= {r_wp[0], wp_i};
  end
  assign w_wp = r_wp[1];
`else
  assign w_wp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_sh    <= 8'd0;
      r_tx    <= 8'd0;
      r_ptr   <= '0;
      r_waddr <= '0;
      r_wdata <= 8'd0;
      r_rw    <= 1'b0;
      r_nack  <= 1'b0;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      if (w_start) begin
        r_state <= S_DEV_ADDR;
        r_cnt   <= 4'd0;
        r_oe    <= 1'b0;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        // Count 4'hF parks the byte counter so a refused write byte never re-triggers.
        if (w_rise && r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
        if (w_rise) r_sh <= {r_sh[6:0], w_sda};
        case (r_state)
          S_DEV_ADDR: if (w_fall && r_cnt == 4'd8) begin
            if (r_sh[7:1] == DEV_ADDR) begin
              r_oe    <= 1'b1;
              r_rw    <= r_sh[0];
              r_busy  <= 1'b1;
              r_state <= S_DEV_ACK;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          S_DEV_ACK: if (w_fall) begin
            r_cnt <= 4'd0;
            if (r_rw) begin
              r_tx    <= r_mem[r_ptr];
              r_oe    <= ~r_mem[r_ptr][7];
              r_state <= S_RD_DATA;
            end else begin
              r_oe    <= 1'b0;
              r_state <= S_WORD_ADDR;
            end
          end
          S_WORD_ADDR: if (w_fall && r_cnt == 4'd8) begin
            r_ptr   <= r_sh[ADDR_W-1:0];
            r_oe    <= 1'b1;
            r_state <= S_WORD_ACK;
          end
          S_WORD_ACK, S_WR_ACK: if (w_fall) begin
            r_cnt   <= 4'd0;
            r_oe    <= 1'b0;
            r_state <= S_WR_DATA;
          end
          S_WR_DATA: if (w_fall && r_cnt == 4'd8) begin
            if (w_wp) begin
              r_cnt <= 4'hF;
            end else begin
              r_stb   <= 1'b1;
              r_waddr <= r_ptr;
              r_wdata <= r_sh;
              r_ptr   <= (r_ptr & ~PMASK) | ((r_ptr + ADDR_W'(1)) & PMASK);
              r_oe    <= 1'b1;
              r_state <= S_WR_ACK;
            end
          end
          S_RD_DATA: if (w_fall) begin
            if (r_cnt == 4'd8) begin
              r_oe    <= 1'b0;
              r_state <= S_RD_ACK;
            end else begin
              r_tx <= {r_tx[6:0], 1'b0};
              r_oe <= ~r_tx[6];
            end
          end
          S_RD_ACK: begin
            if (w_rise) begin
              r_ptr  <= r_ptr + ADDR_W'(1);
              r_nack <= w_sda;
            end
            if (w_fall) begin
              if (r_nack) begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_cnt   <= 4'd0;
                r_tx    <= r_mem[r_ptr];
                r_oe    <= ~r_mem[r_ptr][7];
                r_state <= S_RD_DATA;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_stb) r_mem[r_waddr] <= r_wdata;
  end

  assign bus.sda_oe = r_oe;
  assign busy       = r_busy;
  assign wr_stb     = r_stb;
  assign wr_addr    = r_waddr;
  assign wr_data    = r_wdata;

endmodule
